// File: rtl/icache_loader.sv
// Streams a little-endian program image into instruction memory and holds the core in reset until done.
// Optional trailing checksum word is enabled with `define ICACHE_LOADER_CHECKSUM_EN.
module icache_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        wen,
  output logic        core_nrst,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef ICACHE_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q, state_d, fin_state;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] len_q, len_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [31:0] word;
  logic        accept, word_end;
`ifdef ICACHE_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

`ifdef ICACHE_LOADER_CHECKSUM_EN
  assign fin_state = S_CHK;
`else
  assign fin_state = S_DONE;
`endif

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_LEN, S_DATA: in_ready = 1'b1;
`ifdef ICACHE_LOADER_CHECKSUM_EN
      S_CHK:         in_ready = 1'b1;
`endif
      default:       in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign word_end  = accept && (cnt_q == 2'd3);
  // Earlier bytes sit in asm_q with the first byte lowest; the current byte completes the top.
  assign word      = {in_data, asm_q};
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign wen       = wen_q;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign core_nrst = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    asm_d   = asm_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
`ifdef ICACHE_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (accept) begin
      asm_d = word[31:8];
      cnt_d = cnt_q + 2'd1;
    end
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN;
          cnt_d   = '0;
          idx_d   = '0;
`ifdef ICACHE_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_LEN: begin
        if (word_end) begin
          if (word == '0) begin
            state_d = fin_state;
          end else if (word > MAX_WORDS) begin
            state_d = S_ERROR;
          end else begin
            len_d   = word;
            idx_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_end) begin
          wen_d   = 1'b1;
          waddr_d = BASE_ADDR + idx_q;
          wdata_d = word;
          idx_d   = idx_q + 32'd1;
`ifdef ICACHE_LOADER_CHECKSUM_EN
          sum_d   = sum_q + word;
`endif
          if (idx_q == len_q - 32'd1) state_d = fin_state;
        end
      end
`ifdef ICACHE_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (word_end) state_d = (word == sum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      asm_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
`ifdef ICACHE_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      asm_q   <= asm_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
`ifdef ICACHE_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

endmodule

// File: doc/icache_loader.md
# icache_loader

Writes a program image into the instruction memory through its write port (`waddr`/`wdata`/`wen`), the port the fetch stage leaves tied off. It accepts a byte stream with a valid/ready handshake, assembles little-endian 32-bit words, and writes them to consecutive word addresses. It holds the core in reset until the image is complete.

## Interface
- `BASE_ADDR`, default 0: word address of the first instruction written.
- `MAX_WORDS`, default 1024: largest image length accepted, in words.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE and ERROR.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader accepts a byte when `in_valid && in_ready`.
- `waddr`  out  32  memory write address (word-addressed).
- `wdata`  out  32  memory write data.
- `wen`  out  1  memory write enable, one-cycle pulse per word.
- `core_nrst`  out  1  active-low reset to the core; low until load completes.
- `done`  out  1  high in DONE.
- `error`  out  1  high in ERROR.

## Operation
- Image format, in stream order:
  - 4-byte length `N` (words), little-endian;
  - then `N` words, 4 bytes each, little-endian (first byte goes to `[7:0]`);
  - then, with checksum enabled, one checksum word.
- States:
  - IDLE: `in_ready`=0; `start` → LEN.
  - LEN: `in_ready`=1; collects 4 bytes. Then:
    - `N`=0 → CHK if checksum enabled, else DONE;
    - `N`>`MAX_WORDS` → ERROR;
    - otherwise → DATA.
  - DATA: `in_ready`=1; collects words. After the 4th byte of word `i` is accepted, `wen` pulses with `waddr`=`BASE_ADDR`+`i` and `wdata`=the word. After word `N`-1 → CHK if enabled, else DONE.
  - CHK (macro only): collects 4 bytes. Match → DONE; mismatch → ERROR.
  - DONE: `core_nrst`=1, `done`=1, `in_ready`=0; `start` → LEN.
  - ERROR: `core_nrst`=0, `error`=1, `in_ready`=0; `start` → LEN.
- On `start` from DONE or ERROR:
  - `done` and `error` clear;
  - `core_nrst` drops to 0;
  - byte counter, word index and checksum clear.
- The byte counter (2 bits) wraps 3→0 at each word boundary. The word index is 32 bits and never exceeds `MAX_WORDS`.
- Address arithmetic is 32-bit modulo 2^32.
- Cycles with `in_valid`=0 stall collection with no state change; gaps of any length are allowed.
- `start` asserted in LEN, DATA or CHK is ignored.

## Timing
- Reset values:
  - `in_ready`=0, `wen`=0, `waddr`=0, `wdata`=0;
  - `core_nrst`=0, `done`=0, `error`=0;
  - state IDLE.
- `rst` has priority over all inputs. Reset mid-load returns to IDLE next cycle with `wen`=0. Words already written stay in memory.
- `start` sampled at edge *t* → state LEN and `in_ready`=1 from *t*+1.
- Write latency: `wen`, `waddr` and `wdata` are registered and valid in the cycle after the edge that accepts the 4th byte. `wen` is high for exactly one cycle.
- Sustained rate: one byte per cycle, so one write every 4 cycles. No back-pressure from memory.
- Completion:
  - `done` and `core_nrst` rise in the cycle after the final accepted byte (last data byte, or last checksum byte);
  - with `N`=0 and no checksum, they rise the cycle after the last length byte;
  - the final `wen` pulse and the DONE state begin in the same cycle.
- ERROR is entered the cycle after the offending byte (last length byte or last checksum byte).

## Configuration
- `ICACHE_LOADER_CHECKSUM_EN` defined:
  - a running 32-bit sum (mod 2^32) of all data words is kept;
  - a CHK state follows DATA and compares the sum with the trailing word.
- Not defined: no CHK state and no checksum word in the stream; DATA goes straight to DONE. The `error` output exists in both builds.

## Test plan
- Reset then start, stream `02 00 00 00 | 78 56 34 12 | EF BE AD DE` (plus checksum `67 15 E2 F0` when enabled) → `wen` pulses at addr 0 with `12345678` and addr 1 with `DEADBEEF`; `done`=1 and `core_nrst`=1 the cycle after the last byte.
- Same image with random `in_valid` gaps of 0–5 cycles → identical writes; no `wen` during gaps.
- Length `MAX_WORDS`+1 → no `wen`, `error`=1, `core_nrst`=0; a new `start` with a valid image → DONE.
- `N`=0 → zero writes; DONE after the length (and the checksum word `00000000` when enabled).
- Assert `rst` after the 2nd byte of word 1 → IDLE next cycle and no further `wen`. A restart with a fresh image rewrites from `BASE_ADDR`.
- Checksum build, bad checksum `00 00 00 00` for the 2-word image → both writes occur, then `error`=1 and `done`=0.
